// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking that shares one FIFO write port between several sources.
// Grant and write outputs are combinational from registered state and the current requests.
module fifo_write_arbiter #(
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned BURST      = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [REQUESTERS-1:0]          request,
   input  logic [REQUESTERS*WIDTH-1:0]    request_data,
   output logic [REQUESTERS-1:0]          grant,
   output logic                           write_enable,
   output logic [WIDTH-1:0]               write_data,
   input  logic                           write_full
);

   localparam int unsigned OwnerW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int unsigned CountW = $clog2(BURST + 1);

   typedef logic [OwnerW-1:0] idx_t;
   typedef logic [CountW-1:0] cnt_t;
   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   localparam idx_t LastIdx  = idx_t'(REQUESTERS - 1);
   localparam cnt_t BurstCnt = cnt_t'(BURST);

   state_e state_q, state_d;
   idx_t   owner_q, owner_d;
   idx_t   pointer_q, pointer_d;
   cnt_t   count_q, count_d;

   idx_t   search_start;
   idx_t   scan_idx;
   idx_t   winner;
   logic   found;
   logic   owner_holds;
   idx_t   grant_idx;
   logic   grant_vld;

   // Modulo increment that also works for non-power-of-2 source counts.
   function automatic idx_t wrap_inc(input idx_t i);
      return (i == LastIdx) ? '0 : i + idx_t'(1);
   endfunction

   always_comb begin
      owner_holds  = (state_q == StLocked) && request[owner_q];
      search_start = (state_q == StLocked) ? wrap_inc(owner_q) : pointer_q;
      found        = 1'b0;
      winner       = '0;
      scan_idx     = search_start;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (!found && request[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
         scan_idx = wrap_inc(scan_idx);
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      pointer_d = pointer_q;
      count_d   = count_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      if (!write_full) begin
         if (owner_holds) begin
            grant_vld = 1'b1;
            grant_idx = owner_q;
            count_d   = count_q + cnt_t'(1);
            if (count_q + cnt_t'(1) == BurstCnt) begin
               state_d   = StIdle;
               pointer_d = wrap_inc(owner_q);
            end
         end else if (found) begin
            // Covers both idle arbitration and a lock released by its owner.
            grant_vld = 1'b1;
            grant_idx = winner;
            if (BURST == 1) begin
               state_d   = StIdle;
               pointer_d = wrap_inc(winner);
            end else begin
               state_d = StLocked;
               owner_d = winner;
               count_d = cnt_t'(1);
            end
         end
      end
      if (reset) begin
         grant_vld = 1'b0;
      end
   end

   always_comb begin
      grant      = '0;
      write_data = '0;
      if (grant_vld) begin
         grant[grant_idx] = 1'b1;
      end
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (grant[i]) begin
            write_data = request_data[i*WIDTH +: WIDTH];
         end
      end
      write_enable = grant_vld;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         pointer_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         pointer_q <= pointer_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized scoreboard bench for fifo_write_arbiter (4 sources, 8-bit data, burst 4).
module tb_fifo_write_arbiter;

   localparam int unsigned R = 4;
   localparam int unsigned W = 8;
   localparam int unsigned B = 4;
   localparam int unsigned FairMax = (R - 1) * B;

   logic           clock = 1'b0;
   logic           reset;
   logic [R-1:0]   request;
   logic [R*W-1:0] request_data;
   logic [R-1:0]   grant;
   logic           write_enable;
   logic [W-1:0]   write_data;
   logic           write_full;

   int unsigned total  = 0;
   int unsigned passed = 0;

   logic [W-1:0]   sb [R][$];
   logic [W-1:0]   fifo_m [$];
   int unsigned    wait_c [R];
   logic [R-1:0]   granted_last;
   logic [W-1:0]   rnd_d;

   fifo_write_arbiter #(
      .REQUESTERS (R),
      .WIDTH      (W),
      .BURST      (B)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .request      (request),
      .request_data (request_data),
      .grant        (grant),
      .write_enable (write_enable),
      .write_data   (write_data),
      .write_full   (write_full)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      request    = '0;
      write_full = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic bit sb_all_empty();
      for (int i = 0; i < R; i++) begin
         if (sb[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic score();
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("we_or", 32'(write_enable), 32'(|grant));
      if (write_full) check("full_nogrant", 32'(grant), 32'd0);
      granted_last = grant;
      for (int i = 0; i < R; i++) begin
         if (grant[i]) begin
            check("gnt_req", 32'(request[i]), 32'd1);
            check("sb_nonempty", 32'(sb[i].size() != 0), 32'd1);
            if (sb[i].size() != 0) check("order_data", 32'(write_data), 32'(sb[i].pop_front()));
            fifo_m.push_back(write_data);
            check("fifo_ovf", 32'(fifo_m.size() <= 4), 32'd1);
            wait_c[i] = 0;
         end else if (request[i] && !write_full) begin
            wait_c[i]++;
            check("fairness", 32'(wait_c[i] <= FairMax), 32'd1);
         end
      end
   endtask

   initial begin
      // Reset forces outputs low even with every source requesting.
      reset        = 1'b1;
      write_full   = 1'b0;
      request      = 4'hF;
      request_data = 32'h13121110;
      next_cycle();
      mid();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_we", 32'(write_enable), 32'd0);
      check("rst_wd", 32'(write_data), 32'd0);
      next_cycle();
      reset = 1'b0;

      // Burst rotation starting at source 0.
      for (int c = 0; c < 17; c++) begin
         if (c > 0) next_cycle();
         mid();
         check("rot_grant", 32'(grant), 32'(1 << ((c / 4) % 4)));
         check("rot_data", 32'(write_data), 32'(8'h10 + 8'((c / 4) % 4)));
      end

      // Single source.
      do_reset();
      request      = 4'b0100;
      request_data = 32'h005A0000;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cycle();
         mid();
         check("single_grant", 32'(grant), 32'h4);
         check("single_data", 32'(write_data), 32'h5A);
      end

      // Early release of a lock by source 1.
      do_reset();
      request      = 4'b1110;
      request_data = 32'hD3D2D1D0;
      mid();
      check("er_g1a", 32'(grant), 32'h2);
      next_cycle();
      mid();
      check("er_g1b", 32'(grant), 32'h2);
      next_cycle();
      request = 4'b1100;
      mid();
      check("er_release", 32'(grant), 32'h4);
      check("er_data", 32'(write_data), 32'hD2);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         mid();
         check("er_src2_burst", 32'(grant), 32'h4);
      end
      next_cycle();
      mid();
      check("er_src3", 32'(grant), 32'h8);

      // Backpressure mid-burst keeps lock and count.
      do_reset();
      request      = 4'hF;
      request_data = 32'h44332211;
      mid();
      check("bp_g0a", 32'(grant), 32'h1);
      next_cycle();
      mid();
      check("bp_g0b", 32'(grant), 32'h1);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         write_full = 1'b1;
         mid();
         check("bp_full_grant", 32'(grant), 32'd0);
         check("bp_full_we", 32'(write_enable), 32'd0);
         check("bp_full_wd", 32'(write_data), 32'd0);
      end
      next_cycle();
      write_full = 1'b0;
      mid();
      check("bp_g0c", 32'(grant), 32'h1);
      next_cycle();
      mid();
      check("bp_g0d", 32'(grant), 32'h1);
      next_cycle();
      mid();
      check("bp_g1", 32'(grant), 32'h2);

      // Randomized scoreboard run.
      do_reset();
      granted_last = '0;
      for (int i = 0; i < R; i++) wait_c[i] = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         next_cycle();
         if (fifo_m.size() > 0 && $urandom_range(0, 1) == 1) void'(fifo_m.pop_front());
         for (int i = 0; i < R; i++) begin
            if (granted_last[i]) request[i] = 1'b0;
            if (!request[i] && $urandom_range(0, 1) == 1) begin
               rnd_d = W'($urandom);
               request[i] = 1'b1;
               request_data[i*W +: W] = rnd_d;
               sb[i].push_back(rnd_d);
            end
         end
         write_full = (fifo_m.size() >= 4) || ($urandom_range(0, 9) < 3);
         mid();
         score();
      end

      // Drain outstanding words with no new requests.
      for (int cyc = 0; cyc < 200 && !sb_all_empty(); cyc++) begin
         next_cycle();
         if (fifo_m.size() > 0) void'(fifo_m.pop_front());
         for (int i = 0; i < R; i++) begin
            if (granted_last[i]) request[i] = 1'b0;
         end
         write_full = (fifo_m.size() >= 4);
         mid();
         score();
      end
      for (int i = 0; i < R; i++) check("drained", 32'(sb[i].size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
